sipo_deser: RTL and testbench
=============================

Name: sipo_deser

Overview:
Serial-in/parallel-out deserializer that sits directly downstream of the single-bit D flip-flop stage. It consumes the registered serial bit stream (`q` of the flop, driven here as `din`) and assembles WIDTH-bit words, LSB first. Each completed word is presented on a one-entry output register with a valid/ready handshake. Lost words are flagged by a sticky overrun bit.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  1  serial data bit.
- din_valid  input  1  din is sampled this cycle when 1.
- sync  input  1  word-alignment restart.
- dout  output  WIDTH  assembled word; bit 0 is the first bit received.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready.
- overrun  output  1  sticky: a completed word was dropped.
- par_err  output  1  parity error for the word in dout; qualified by dout_valid.

Behaviour:
- Reset, synchronous: rst=1 at a rising edge gives:
  - dout=0, dout_valid=0, overrun=0, par_err=0;
  - bit counter=0, shift register=0, FSM=S_DATA.
- Reset takes priority over every other input. A partial word in progress at reset is discarded.
- FSM states:
  - S_DATA: collecting data bits.
  - S_PAR: collecting the parity bit. Exists only with the optional feature.
- Bit accept: on each edge with din_valid=1 in S_DATA:
  - shift[cnt] <= din;
  - cnt increments.
  - din_valid=0: no state change, counter holds.
- Word complete: this is the accept edge of bit cnt=WIDTH-1 (without parity).
  - cnt wraps to 0.
  - The word is offered to the output register on that same edge.
- Latency: dout_valid rises on the edge that samples the last bit. It is visible the cycle after the last bit is presented.
- Output register load rule, evaluated at the completing edge:
  - dout_valid=0: load dout, set dout_valid=1.
  - dout_valid=1 and dout_ready=1 (drain and complete in the same cycle): load the new word, dout_valid stays 1, no bubble.
  - dout_valid=1 and dout_ready=0: the new word is dropped, dout is unchanged, overrun <= 1. overrun clears only on rst.
- Handshake:
  - dout_valid=1 with dout_ready=1 and no completing word: dout_valid <= 0, dout holds its last value.
  - dout and dout_valid never change while dout_valid=1 and dout_ready=0, except on rst.
  - dout_ready is ignored while dout_valid=0.
- sync=1 on an edge:
  - Any partial word is discarded and the FSM returns to S_DATA.
  - If din_valid=1 on that same edge, din is taken as bit 0 and cnt becomes 1. Otherwise cnt becomes 0.
  - sync never affects the output register or overrun.
  - sync on what would be a completing edge: the completion is cancelled and no word is produced.
- Widths:
  - Counter width is clog2(WIDTH+1).
  - Shift register is WIDTH bits, written by index (no shifting), so partial bits never move.

Optional Feature:
- Macro SIPO_PARITY_EN defined:
  - After bit WIDTH-1 the FSM moves to S_PAR instead of completing.
  - The next accepted bit is an even-parity bit over the WIDTH data bits.
  - Its accept edge is the completing edge: the load rules above apply, with par_err loaded alongside dout as (^data) ^ parity_bit.
  - sync in S_PAR returns the FSM to S_DATA per the sync rule.
  - Frame length is WIDTH+1 bits.
- Macro undefined: no S_PAR state, frames are WIDTH bits, and par_err is tied 0.

Test Plan:
- Reset: hold rst=1 for 2 cycles with din_valid=1, din=1 → dout=0, dout_valid=0, overrun=0. Release, send 8 bits → exactly one word, proving no partial bits survive reset.
- Basic word (WIDTH=8): dout_ready=1, send din=1,0,1,1,0,0,1,0 on consecutive din_valid cycles → dout=8'h4D; dout_valid=1 for exactly one cycle, starting the cycle after the 8th bit.
- Gaps and backpressure:
  - Send 8'hA5 with din_valid=0 idle cycles between bits, dout_ready=0 → dout=8'hA5 holds stably for 10 cycles.
  - Raise dout_ready for 1 cycle → dout_valid=0 on the next cycle.
- Back-to-back and overrun:
  - dout_ready=1 at the completing edge of word 2 (first word 8'h11, then 8'h22) → dout_valid stays high and dout=8'h22.
  - Then dout_ready=0, send 8'h33 then 8'h44 → dout=8'h33, 8'h44 dropped, overrun=1 until rst.
- Sync realignment: send 5 bits, then sync=1 with din_valid=1, din=1, then 7 more bits of 0 → dout=8'h01. sync=1 alone on a completing edge → no dout_valid.
- SIPO_PARITY_EN build:
  - Send 8'h4D + parity 0 → dout=8'h4D, par_err=0.
  - Send 8'h4D + parity 1 → par_err=1.
  - Confirm dout_valid asserts only after the 9th bit.

Source files
------------

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: LSB-first WIDTH-bit words into a one-entry valid/ready output register.
// Optional even-parity frame bit enabled by defining SIPO_PARITY_EN.
module sipo_deser #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
    output logic             par_err
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

`ifdef SIPO_PARITY_EN
    typedef enum logic {S_DATA, S_PAR} state_t;
`else
    typedef enum logic {S_DATA} state_t;
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overrun_q, overrun_d;
    logic             word_done;
    logic [WIDTH-1:0] word;
`ifdef SIPO_PARITY_EN
    logic             par_err_q, par_err_d;
    logic             word_par;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        word_done = 1'b0;
`ifdef SIPO_PARITY_EN
        word_par  = 1'b0;
`endif
        if (sync) begin
            // Realignment wins over completion; a bit arriving with sync starts the new word.
            state_d = S_DATA;
            cnt_d   = '0;
            if (din_valid) begin
                shift_d[0] = din;
                cnt_d      = CW'(1);
            end
        end else if (din_valid) begin
`ifdef SIPO_PARITY_EN
            if (state_q == S_PAR) begin
                word_done = 1'b1;
                word_par  = (^shift_q) ^ din;
                state_d   = S_DATA;
                cnt_d     = '0;
            end else
`endif
            begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    if (cnt_q == CW'(i)) shift_d[i] = din;
                end
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d = '0;
`ifdef SIPO_PARITY_EN
                    state_d = S_PAR;
`else
                    word_done = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
        word = shift_d;
    end

    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = overrun_q;
`ifdef SIPO_PARITY_EN
        par_err_d    = par_err_q;
`endif
        if (word_done) begin
            if (!dout_valid_q || dout_ready) begin
                dout_d       = word;
                dout_valid_d = 1'b1;
`ifdef SIPO_PARITY_EN
                par_err_d    = word_par;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end else if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_DATA;
            cnt_q        <= '0;
            shift_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef SIPO_PARITY_EN
            par_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
`ifdef SIPO_PARITY_EN
            par_err_q    <= par_err_d;
`endif
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overrun    = overrun_q;
`ifdef SIPO_PARITY_EN
    assign par_err    = par_err_q;
`else
    assign par_err    = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser (WIDTH=8): directed scenarios plus randomized traffic against a frame-level model.
module tb_sipo_deser;

    localparam int unsigned W = 8;
`ifdef SIPO_PARITY_EN
    localparam int unsigned FRAME = W + 1;
`else
    localparam int unsigned FRAME = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         din = 1'b0;
    logic         din_valid = 1'b0;
    logic         sync = 1'b0;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready = 1'b0;
    logic         overrun;
    logic         par_err;

    int checks = 0;
    int failures = 0;

    // Frame-level reference: collected bits, and the output register contents.
    int           frame_q[$];
    logic [W-1:0] m_dout = '0;
    bit           m_valid = 1'b0;
    bit           m_over = 1'b0;
    bit           m_par = 1'b0;

    sipo_deser #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .sync       (sync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overrun    (overrun),
        .par_err    (par_err)
    );

    always #5 clk = ~clk;

    task automatic step(input bit v, input bit d, input bit s, input bit r);
        bit           done;
        logic [W-1:0] w;
        int           ones;
        din_valid = v;
        din = d;
        sync = s;
        dout_ready = r;
        @(posedge clk);
        done = 1'b0;
        w = '0;
        ones = 0;
        if (rst) begin
            frame_q.delete();
            m_dout = '0;
            m_valid = 1'b0;
            m_over = 1'b0;
            m_par = 1'b0;
        end else begin
            if (s) begin
                frame_q.delete();
                if (v) frame_q.push_back(int'(d));
            end else if (v) begin
                frame_q.push_back(int'(d));
                if (frame_q.size() == FRAME) begin
                    done = 1'b1;
                    for (int i = 0; i < FRAME; i++) begin
                        ones += frame_q[i];
                        if (i < W && frame_q[i] != 0) w = w + (W'(1) << i);
                    end
                    frame_q.delete();
                end
            end
            if (done) begin
                if (!m_valid || r) begin
                    m_dout = w;
                    m_valid = 1'b1;
                    m_par = (FRAME > W) ? ((ones % 2) == 1) : 1'b0;
                end else begin
                    m_over = 1'b1;
                end
            end else if (m_valid && r) begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    function automatic bit frame_bit(input logic [W-1:0] w, input int i, input bit bad_par);
        logic [W-1:0] t;
        t = w;
        if (i < W) return t[i];
        return ($countones(t) % 2 == 1) ^ bad_par;
    endfunction

    task automatic send_frame(input logic [W-1:0] w, input bit bad_par, input int max_gap,
                              input bit rdy, input bit rdy_last);
        for (int i = 0; i < FRAME; i++) begin
            if (max_gap > 0) begin
                int g;
                g = $urandom_range(max_gap, 1);
                for (int k = 0; k < g; k++) step(1'b0, 1'b0, 1'b0, rdy);
            end
            step(1'b1, frame_bit(w, i, bad_par), 1'b0, (i == FRAME - 1) ? rdy_last : rdy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dout !== '0 || dout_valid !== 1'b0 || overrun !== 1'b0 || par_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: dout=%h valid=%b overrun=%b par_err=%b, want 00 0 0 0",
                     dout, dout_valid, overrun, par_err);
        end
        for (int i = 0; i < FRAME; i++) begin
            step(1'b1, frame_bit(8'hFF, i, 1'b0), 1'b0, 1'b0);
            if (i < FRAME - 1) begin
                checks++;
                if (dout_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_no_partial: bit %0d valid=%b, want 0", i, dout_valid);
                end
            end
        end
        checks++;
        if (dout_valid !== 1'b1 || dout !== 8'hFF) begin
            failures++;
            $display("FAIL reset_first_word: valid=%b dout=%h, want 1 ff", dout_valid, dout);
        end
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 0; i < FRAME; i++) begin
            step(1'b1, frame_bit(8'h4D, i, 1'b0), 1'b0, 1'b1);
            if (i < FRAME - 1) begin
                checks++;
                if (dout_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL basic_early_valid: bit %0d valid=%b, want 0", i, dout_valid);
                end
            end
        end
        checks++;
        if (dout_valid !== 1'b1 || dout !== 8'h4D || par_err !== 1'b0) begin
            failures++;
            $display("FAIL basic_word: valid=%b dout=%h par_err=%b, want 1 4d 0", dout_valid, dout, par_err);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (dout_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_one_cycle: valid=%b, want 0", dout_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        send_frame(8'hA5, 1'b0, 3, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (dout_valid !== 1'b1 || dout !== 8'hA5) begin
                failures++;
                $display("FAIL backpressure_hold: cycle %0d valid=%b dout=%h, want 1 a5", i, dout_valid, dout);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (dout_valid !== 1'b0 || dout !== 8'hA5) begin
            failures++;
            $display("FAIL backpressure_drain: valid=%b dout=%h, want 0 a5", dout_valid, dout);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_frame(8'h11, 1'b0, 0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 0, 1'b0, 1'b1);
        checks++;
        if (dout_valid !== 1'b1 || dout !== 8'h22 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL b2b_replace: valid=%b dout=%h overrun=%b, want 1 22 0", dout_valid, dout, overrun);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h33, 1'b0, 0, 1'b0, 1'b0);
        send_frame(8'h44, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (dout_valid !== 1'b1 || dout !== 8'h33 || overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_drop: valid=%b dout=%h overrun=%b, want 1 33 1", dout_valid, dout, overrun);
        end
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_sticky: overrun=%b, want 1", overrun);
        end
        do_reset();
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clear: overrun=%b, want 0", overrun);
        end
    endtask

    task automatic test_sync();
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom_range(1, 0)), 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < FRAME; i++) step(1'b1, frame_bit(8'h01, i, 1'b0), 1'b0, 1'b0);
        checks++;
        if (dout_valid !== 1'b1 || dout !== 8'h01 || par_err !== 1'b0) begin
            failures++;
            $display("FAIL sync_realign: valid=%b dout=%h par_err=%b, want 1 01 0", dout_valid, dout, par_err);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        // sync with a bit on the would-be completing edge: no word, bit becomes bit 0
        for (int i = 0; i < FRAME - 1; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (dout_valid !== 1'b0) begin
            failures++;
            $display("FAIL sync_cancel: valid=%b, want 0", dout_valid);
        end
        for (int i = 1; i < FRAME; i++) step(1'b1, frame_bit(8'h80, i, 1'b0), 1'b0, 1'b0);
        checks++;
        if (dout_valid !== 1'b1 || dout !== 8'h80) begin
            failures++;
            $display("FAIL sync_bit0: valid=%b dout=%h, want 1 80", dout_valid, dout);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        // sync alone after FRAME-1 bits, then one bit: still no word
        for (int i = 0; i < FRAME - 1; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dout_valid !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL sync_alone: valid=%b overrun=%b, want 0 0", dout_valid, overrun);
        end
    endtask

`ifdef SIPO_PARITY_EN
    task automatic test_parity();
        do_reset();
        for (int i = 0; i < FRAME; i++) begin
            step(1'b1, frame_bit(8'h4D, i, 1'b0), 1'b0, 1'b1);
            if (i == W - 1) begin
                checks++;
                if (dout_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL parity_early: valid=%b after data bits, want 0", dout_valid);
                end
            end
        end
        checks++;
        if (dout_valid !== 1'b1 || dout !== 8'h4D || par_err !== 1'b0) begin
            failures++;
            $display("FAIL parity_good: valid=%b dout=%h par_err=%b, want 1 4d 0", dout_valid, dout, par_err);
        end
        send_frame(8'h4D, 1'b1, 0, 1'b1, 1'b1);
        checks++;
        if (dout_valid !== 1'b1 || dout !== 8'h4D || par_err !== 1'b1) begin
            failures++;
            $display("FAIL parity_bad: valid=%b dout=%h par_err=%b, want 1 4d 1", dout_valid, dout, par_err);
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            step(1'($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)),
                 1'($urandom_range(40, 0) == 0), 1'($urandom_range(2, 0) != 0));
            checks++;
            if (dout_valid !== m_valid || overrun !== m_over ||
                (m_valid && (dout !== m_dout || par_err !== m_par))) begin
                failures++;
                $display("FAIL random_cycle %0d: valid=%b dout=%h ovr=%b par=%b, want %b %h %b %b",
                         n, dout_valid, dout, overrun, par_err, m_valid, m_dout, m_over, m_par);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_sync();
`ifdef SIPO_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
